// File: rtl/id_operand_stage.sv
`timescale 1ns/1ps
// id_operand_stage: IF->ID pipeline register, instruction replay buffer for the
// one-cycle-latency instruction SRAM, and prioritised rs/rt operand forwarding
// with load-use stall request generation.
module id_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NFWD    = 3,
    parameter int STALL_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 if_ce,
    input  logic [XLEN-1:0]      if_pc,
    input  logic [31:0]          inst_rdata,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [5*NFWD-1:0]    fwd_waddr,
    input  logic [XLEN*NFWD-1:0] fwd_wdata,
    input  logic [NFWD-1:0]      fwd_ready,
    output logic [4:0]           rf_raddr1,
    output logic [4:0]           rf_raddr2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic                 use_src1,
    input  logic                 use_src2,
    output logic                 id_valid,
    output logic [XLEN-1:0]      id_pc,
    output logic [31:0]          id_inst,
    output logic [XLEN-1:0]      src1,
    output logic [XLEN-1:0]      src2,
    output logic                 stallreq
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } hold_state_t;

    hold_state_t hold_state;
    hold_state_t hold_state_next;
    logic [31:0] hold_inst;
    logic [31:0] hold_inst_next;
    logic        hold_v;
    logic        id_stall;
    logic        ex_stall;
    logic        bubble;
    logic        hazard1;
    logic        hazard2;
    logic        stall_unused;

    assign id_stall     = stall[1];
    assign ex_stall     = stall[2];
    assign bubble       = id_stall & ~ex_stall;
    assign stall_unused = ^{stall[0], stall[STALL_W-1:3]};

    // IF->ID register: flush beats bubble beats load; otherwise the slot holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
        end else if (flush || bubble) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
        end else if (!id_stall) begin
            id_valid <= if_ce;
            id_pc    <= if_pc;
        end
    end

    // Replay buffer state register; the SRAM word is only presented for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_state <= EMPTY;
            hold_inst  <= '0;
        end else begin
            hold_state <= hold_state_next;
            hold_inst  <= hold_inst_next;
        end
    end

    // Capture the live SRAM word when a valid slot starts being held; drop it on release.
    always_comb begin
        hold_state_next = hold_state;
        hold_inst_next  = hold_inst;
        case (hold_state)
            EMPTY: begin
                if (id_valid && id_stall && ex_stall && !flush) begin
                    hold_state_next = HELD;
                    hold_inst_next  = inst_rdata;
                end
            end
            HELD: begin
                if (flush || bubble || !id_stall) begin
                    hold_state_next = EMPTY;
                end
            end
        endcase
    end

    assign hold_v    = (hold_state == HELD);
    assign id_inst   = !id_valid ? 32'd0 : (hold_v ? hold_inst : inst_rdata);
    assign rf_raddr1 = id_inst[25:21];
    assign rf_raddr2 = id_inst[20:16];

    // Operand resolution: scan oldest to youngest so the youngest match ends up winning.
    always_comb begin
        src1    = rf_rdata1;
        src2    = rf_rdata2;
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[5*i +: 5] == rf_raddr1)) begin
                src1    = fwd_wdata[XLEN*i +: XLEN];
                hazard1 = ~fwd_ready[i];
            end
            if (fwd_we[i] && (fwd_waddr[5*i +: 5] == rf_raddr2)) begin
                src2    = fwd_wdata[XLEN*i +: XLEN];
                hazard2 = ~fwd_ready[i];
            end
        end
        if (rf_raddr1 == 5'd0) begin
            src1    = '0;
            hazard1 = 1'b0;
        end
        if (rf_raddr2 == 5'd0) begin
            src2    = '0;
            hazard2 = 1'b0;
        end
    end

    assign stallreq = id_valid & ((use_src1 & hazard1) | (use_src2 & hazard2));

endmodule
